router_pkt_src: RTL and testbench
=================================

# router_pkt_src

Upstream packet source for the 1x3 router core. Accepts a packet request (destination, length) and its payload words over valid/ready, buffers the whole payload, then serializes header, length, payload and parity words onto the router's 3-bit input link. It honours the router's `busy` back-pressure and counts parity errors the router flags. Sits between the host-side stimulus/control logic and the router `data_in`/`packet_valid` inputs.

## Interface
- `MAX_LEN`, 7: maximum payload words per packet; `req_len` legal range is 1..`MAX_LEN`.
- `GAP_CYCLES`, 2: idle cycles after parity before the next request is accepted; `err` is sampled in the last one.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  packet request valid.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_addr`  in  2  destination port 0..2; 3 is illegal.
- `req_len`  in  3  payload word count 1..7; 0 is illegal.
- `pay_valid`  in  1  payload word valid.
- `pay_ready`  out  1  payload word accepted when `pay_valid & pay_ready`.
- `pay_data`  in  3  payload word.
- `packet_valid`  out  1  drives router `packet_valid`.
- `data_out`  out  3  drives router `data_in`.
- `busy`  in  1  router back-pressure.
- `err`  in  1  router parity-error flag.
- `done`  out  1  one-cycle pulse when the parity word transfers.
- `bad_req`  out  1  one-cycle pulse when an illegal request is dropped.
- `err_cnt`  out  4  saturating count of packets flagged by `err`.

## Operation
- FSM states: IDLE, LOAD, HEADER, LENGTH, PAYLOAD, PARITY, GAP.
- IDLE: `req_ready`=1. On accept, latch addr/len and clear the parity accumulator.
  - If addr==3 or len==0: pulse `bad_req` next cycle and stay in IDLE.
  - Otherwise go to LOAD.
- LOAD: `pay_ready`=1. Each accepted word goes into an internal buffer (depth `MAX_LEN`, write index 0..len-1). After word len-1 is accepted, go to HEADER. `pay_ready`=0 in every other state.
- Word formats, with `packet_valid`=1 for all three:
  - HEADER: `data_out`={1'b0, addr}.
  - LENGTH: `data_out`=len.
  - PAYLOAD: `data_out`=buffer[i], i=0..len-1.
- PARITY: `data_out` = XOR of header, length and all payload words; `packet_valid`=0.
- A word transfers on a cycle where the FSM is in HEADER/LENGTH/PAYLOAD/PARITY and `busy`=0.
  - `busy`=1: hold state, `data_out` and `packet_valid` unchanged.
  - The parity accumulator updates only on transfer.
- Parity transfer: pulse `done` and go to GAP.
- GAP: `packet_valid`=0, `data_out`=0, for `GAP_CYCLES` cycles.
  - In the last GAP cycle, if `err`=1, `err_cnt` += 1, saturating at 15.
  - Then go to IDLE.
- `req_*` and `pay_*` inputs are ignored outside IDLE and LOAD respectively.
- Reset mid-packet: the packet is abandoned immediately; nothing resumes after reset.

## Timing
- All outputs are registered.
- Reset values:
  - Outputs: `req_ready`=1, `pay_ready`=0, `packet_valid`=0, `data_out`=0, `done`=0, `bad_req`=0, `err_cnt`=0.
  - Internal: state=IDLE, buffer index=0, parity accumulator=0.
- Reference timeline, with `busy`=0 and `pay_valid` continuously high; request accepted at cycle 0:
  - Payload accepted cycles 1..len.
  - HEADER driven cycle len+1, LENGTH at len+2.
  - Payload words at len+3..2len+2.
  - PARITY at 2len+3; `done` high in cycle 2len+4.
  - GAP 2len+4..2len+5.
  - `req_ready`=1 again in cycle 2len+6.
- Each cycle of `busy`=1 during HEADER..PARITY adds exactly one cycle to every later event.
- `pay_valid` gaps in LOAD add one cycle each. `packet_valid` never deasserts between header and last payload.
- `bad_req`: asserted the cycle after the illegal accept. `req_ready` stays 1, so back-to-back requests are allowed.
- `busy` asserted in the same cycle the FSM enters HEADER: header is held, not dropped.

## Test plan
- Reset, then idle 5 cycles -> `req_ready`=1, `packet_valid`=0, `data_out`=0, `err_cnt`=0 throughout.
- addr=1, len=2, payload 5,3, `busy`=0 -> `data_out` sequence 001, 010, 101, 011 with `packet_valid`=1, then parity 101 with `packet_valid`=0; `done` at cycle 8; `req_ready` back at cycle 10.
- Same packet with `busy`=1 for 3 cycles starting while LENGTH is driven -> LENGTH 010 held 4 cycles; all later events shift by +3; parity still 101.
- addr=3, len=4 request, then addr=0, len=0 -> `bad_req` pulses twice; `pay_ready` never asserts; `packet_valid` stays 0.
- addr=2, len=7, payload 7,6,5,4,3,2,1 with `pay_valid` low every other cycle -> LOAD takes 13 cycles; header 010, length 111, parity = 2^7^(7^6^5^4^3^2^1) = 101.
- 17 consecutive legal packets with `err`=1 held -> `err_cnt` reaches 15 and stays 15. Assert `reset` for one cycle during PAYLOAD -> next cycle all outputs at reset values and `err_cnt`=0.

Source files
------------

// File: rtl/router_pkt_src.sv
// router_pkt_src: upstream packet source for the 1x3 router core.
// Buffers a payload, then serializes header/length/payload/parity.
//
// Ports:
//   clock, reset        rising-edge clock, sync active-high reset
//   req_valid/ready     packet request handshake (req_addr, req_len)
//   pay_valid/ready     payload word handshake (pay_data)
//   packet_valid        router packet_valid
//   data_out            router data_in
//   busy                router back-pressure
//   err                 router parity-error flag
//   done                pulse when the parity word transfers
//   bad_req             pulse when an illegal request is dropped
//   err_cnt             saturating count of err-flagged packets
module router_pkt_src #(
    parameter int MAX_LEN    = 7,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_addr,
    input  logic [2:0] req_len,
    input  logic       pay_valid,
    output logic       pay_ready,
    input  logic [2:0] pay_data,
    output logic       packet_valid,
    output logic [2:0] data_out,
    input  logic       busy,
    input  logic       err,
    output logic       done,
    output logic       bad_req,
    output logic [3:0] err_cnt
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, HEADER, LENGTH, PAYLOAD, PARITY, GAP
    } state_t;

    state_t        state, state_d;
    logic [1:0]    addr_q, addr_d;
    logic [2:0]    len_q, len_d;
    logic [2:0]    idx_q, idx_d;
    logic [2:0]    par_q, par_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [2:0]    pbuf [MAX_LEN];
    logic          buf_we;
    logic          last_word;

    logic          req_ready_d, pay_ready_d, packet_valid_d;
    logic          done_d, bad_req_d;
    logic [2:0]    data_out_d;
    logic [3:0]    err_cnt_d;

    assign last_word = (idx_q == (len_q - 3'd1));

    always_comb begin
        state_d        = state;
        addr_d         = addr_q;
        len_d          = len_q;
        idx_d          = idx_q;
        par_d          = par_q;
        gap_d          = gap_q;
        buf_we         = 1'b0;
        req_ready_d    = req_ready;
        pay_ready_d    = pay_ready;
        packet_valid_d = packet_valid;
        data_out_d     = data_out;
        err_cnt_d      = err_cnt;
        done_d         = 1'b0;
        bad_req_d      = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d = req_addr;
                    len_d  = req_len;
                    par_d  = 3'd0;
                    idx_d  = 3'd0;
                    if (req_addr == 2'd3 || req_len == 3'd0) begin
                        bad_req_d = 1'b1;
                    end else begin
                        state_d     = LOAD;
                        req_ready_d = 1'b0;
                        pay_ready_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (pay_valid) begin
                    buf_we = 1'b1;
                    idx_d  = idx_q + 3'd1;
                    if (last_word) begin
                        state_d        = HEADER;
                        idx_d          = 3'd0;
                        pay_ready_d    = 1'b0;
                        packet_valid_d = 1'b1;
                        data_out_d     = {1'b0, addr_q};
                    end
                end
            end
            // The accumulator folds in the word currently on the link,
            // so it only advances on a real transfer.
            HEADER: begin
                if (!busy) begin
                    par_d      = par_q ^ data_out;
                    state_d    = LENGTH;
                    data_out_d = len_q;
                end
            end
            LENGTH: begin
                if (!busy) begin
                    par_d      = par_q ^ data_out;
                    state_d    = PAYLOAD;
                    data_out_d = pbuf[0];
                end
            end
            PAYLOAD: begin
                if (!busy) begin
                    par_d = par_q ^ data_out;
                    if (last_word) begin
                        state_d        = PARITY;
                        idx_d          = 3'd0;
                        packet_valid_d = 1'b0;
                        data_out_d     = par_q ^ data_out;
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        data_out_d = pbuf[idx_q + 3'd1];
                    end
                end
            end
            PARITY: begin
                if (!busy) begin
                    state_d    = GAP;
                    done_d     = 1'b1;
                    data_out_d = 3'd0;
                    gap_d      = '0;
                end
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    if (err && err_cnt != 4'hf) begin
                        err_cnt_d = err_cnt + 4'd1;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            addr_q       <= 2'd0;
            len_q        <= 3'd0;
            idx_q        <= 3'd0;
            par_q        <= 3'd0;
            gap_q        <= '0;
            req_ready    <= 1'b1;
            pay_ready    <= 1'b0;
            packet_valid <= 1'b0;
            data_out     <= 3'd0;
            done         <= 1'b0;
            bad_req      <= 1'b0;
            err_cnt      <= 4'd0;
        end else begin
            state        <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            par_q        <= par_d;
            gap_q        <= gap_d;
            req_ready    <= req_ready_d;
            pay_ready    <= pay_ready_d;
            packet_valid <= packet_valid_d;
            data_out     <= data_out_d;
            done         <= done_d;
            bad_req      <= bad_req_d;
            err_cnt      <= err_cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (buf_we) begin
            pbuf[idx_q] <= pay_data;
        end
    end

endmodule

// File: tb/tb_router_pkt_src.sv
// tb_router_pkt_src: directed vectors and packet sequences
// for router_pkt_src.
module tb_router_pkt_src;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_addr;
    logic [2:0] req_len;
    logic       pay_valid;
    logic       pay_ready;
    logic [2:0] pay_data;
    logic       packet_valid;
    logic [2:0] data_out;
    logic       busy;
    logic       err;
    logic       done;
    logic       bad_req;
    logic [3:0] err_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    router_pkt_src dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .pay_valid   (pay_valid),
        .pay_ready   (pay_ready),
        .pay_data    (pay_data),
        .packet_valid(packet_valid),
        .data_out    (data_out),
        .busy        (busy),
        .err         (err),
        .done        (done),
        .bad_req     (bad_req),
        .err_cnt     (err_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rv;
        logic [1:0] ra;
        logic [2:0] rl;
        logic       pv;
        logic [2:0] pd;
        logic       bz;
        logic       e_rr;
        logic       e_pr;
        logic       e_pkv;
        logic [2:0] e_do;
        logic       e_dn;
        logic       e_br;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(negedge clock);
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic add(input logic rv, input logic [1:0] ra,
                       input logic [2:0] rl, input logic pv,
                       input logic [2:0] pd, input logic bz,
                       input logic rr, input logic pr, input logic pkv,
                       input logic [2:0] dout, input logic dn,
                       input logic br);
        tbl.push_back('{rv, ra, rl, pv, pd, bz, rr, pr, pkv, dout, dn, br});
    endtask

    task automatic chk_idle(input string nm, input logic [3:0] cnt);
        chk({nm, "_req_ready"}, {3'd0, req_ready}, 4'd1);
        chk({nm, "_pay_ready"}, {3'd0, pay_ready}, 4'd0);
        chk({nm, "_pkt_valid"}, {3'd0, packet_valid}, 4'd0);
        chk({nm, "_data_out"}, {1'b0, data_out}, 4'd0);
        chk({nm, "_done"}, {3'd0, done}, 4'd0);
        chk({nm, "_bad_req"}, {3'd0, bad_req}, 4'd0);
        chk({nm, "_err_cnt"}, err_cnt, cnt);
    endtask

    // Entered and left at the negedge of an idle cycle.
    task automatic run_pkt(input logic [1:0] a, input logic [2:0] l,
                           input logic [2:0] d [7], input bit alt,
                           input int hb, input logic [3:0] exp_cnt);
        logic [2:0] par;
        par = {1'b0, a} ^ l;
        chk("pk_req_ready", {3'd0, req_ready}, 4'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        tick();
        req_valid = 1'b0;
        for (int w = 0; w < int'(l); w++) begin
            if (alt && w > 0) begin
                pay_valid = 1'b0;
                chk("pk_load_gap", {3'd0, pay_ready}, 4'd1);
                tick();
            end
            pay_valid = 1'b1;
            pay_data  = d[w];
            par       = par ^ d[w];
            chk("pk_load", {3'd0, pay_ready}, 4'd1);
            chk("pk_load_rr", {3'd0, req_ready}, 4'd0);
            tick();
        end
        pay_valid = 1'b0;
        for (int h = 0; h < hb; h++) begin
            busy = 1'b1;
            chk("pk_hdr_hold", {1'b0, data_out}, {2'd0, a});
            chk("pk_hdr_hold_v", {3'd0, packet_valid}, 4'd1);
            tick();
        end
        busy = 1'b0;
        chk("pk_pay_ready", {3'd0, pay_ready}, 4'd0);
        chk("pk_hdr", {1'b0, data_out}, {2'd0, a});
        chk("pk_hdr_v", {3'd0, packet_valid}, 4'd1);
        tick();
        chk("pk_len", {1'b0, data_out}, {1'b0, l});
        chk("pk_len_v", {3'd0, packet_valid}, 4'd1);
        tick();
        for (int w = 0; w < int'(l); w++) begin
            chk("pk_pay", {1'b0, data_out}, {1'b0, d[w]});
            chk("pk_pay_v", {3'd0, packet_valid}, 4'd1);
            tick();
        end
        chk("pk_par", {1'b0, data_out}, {1'b0, par});
        chk("pk_par_v", {3'd0, packet_valid}, 4'd0);
        chk("pk_par_done", {3'd0, done}, 4'd0);
        tick();
        chk("pk_done", {3'd0, done}, 4'd1);
        chk("pk_gap1_do", {1'b0, data_out}, 4'd0);
        chk("pk_gap1_rr", {3'd0, req_ready}, 4'd0);
        tick();
        chk("pk_gap2_done", {3'd0, done}, 4'd0);
        chk("pk_gap2_rr", {3'd0, req_ready}, 4'd0);
        tick();
        chk("pk_err_cnt", err_cnt, exp_cnt);
    endtask

    initial begin
        logic [2:0] pl [7];
        logic [3:0] ec;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 2'd0;
        req_len   = 3'd0;
        pay_valid = 1'b0;
        pay_data  = 3'd0;
        busy      = 1'b0;
        err       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle("rst", 4'd0);
        end

        // addr=1 len=2 payload 5,3; same with busy on LENGTH;
        // then two illegal requests back to back.
        add(1,1,2, 0,0,0, 1,0,0,0,0,0);
        add(0,0,0, 1,5,0, 0,1,0,0,0,0);
        add(0,0,0, 1,3,0, 0,1,0,0,0,0);
        add(0,0,0, 0,0,0, 0,0,1,1,0,0);
        add(0,0,0, 0,0,0, 0,0,1,2,0,0);
        add(0,0,0, 0,0,0, 0,0,1,5,0,0);
        add(0,0,0, 0,0,0, 0,0,1,3,0,0);
        add(0,0,0, 0,0,0, 0,0,0,5,0,0);
        add(0,0,0, 0,0,0, 0,0,0,0,1,0);
        add(0,0,0, 0,0,0, 0,0,0,0,0,0);
        add(1,1,2, 0,0,0, 1,0,0,0,0,0);
        add(0,0,0, 1,5,0, 0,1,0,0,0,0);
        add(0,0,0, 1,3,0, 0,1,0,0,0,0);
        add(0,0,0, 0,0,0, 0,0,1,1,0,0);
        add(0,0,0, 0,0,1, 0,0,1,2,0,0);
        add(0,0,0, 0,0,1, 0,0,1,2,0,0);
        add(0,0,0, 0,0,1, 0,0,1,2,0,0);
        add(0,0,0, 0,0,0, 0,0,1,2,0,0);
        add(0,0,0, 0,0,0, 0,0,1,5,0,0);
        add(0,0,0, 0,0,0, 0,0,1,3,0,0);
        add(0,0,0, 0,0,0, 0,0,0,5,0,0);
        add(0,0,0, 0,0,0, 0,0,0,0,1,0);
        add(0,0,0, 0,0,0, 0,0,0,0,0,0);
        add(1,3,4, 1,0,0, 1,0,0,0,0,0);
        add(1,0,0, 1,0,0, 1,0,0,0,0,1);
        add(0,0,0, 1,0,0, 1,0,0,0,0,1);
        add(0,0,0, 1,0,0, 1,0,0,0,0,0);

        foreach (tbl[i]) begin
            req_valid = tbl[i].rv;
            req_addr  = tbl[i].ra;
            req_len   = tbl[i].rl;
            pay_valid = tbl[i].pv;
            pay_data  = tbl[i].pd;
            busy      = tbl[i].bz;
            chk($sformatf("v%0d_req_ready", i), {3'd0, req_ready},
                {3'd0, tbl[i].e_rr});
            chk($sformatf("v%0d_pay_ready", i), {3'd0, pay_ready},
                {3'd0, tbl[i].e_pr});
            chk($sformatf("v%0d_pkt_valid", i), {3'd0, packet_valid},
                {3'd0, tbl[i].e_pkv});
            chk($sformatf("v%0d_data_out", i), {1'b0, data_out},
                {1'b0, tbl[i].e_do});
            chk($sformatf("v%0d_done", i), {3'd0, done},
                {3'd0, tbl[i].e_dn});
            chk($sformatf("v%0d_bad_req", i), {3'd0, bad_req},
                {3'd0, tbl[i].e_br});
            tick();
        end
        req_valid = 1'b0;
        pay_valid = 1'b0;
        busy      = 1'b0;

        // addr=2 len=7, pay_valid low every other cycle; parity 101.
        for (int w = 0; w < 7; w++) pl[w] = 3'(7 - w);
        run_pkt(2'd2, 3'd7, pl, 1'b1, 0, 4'd0);

        // 17 legal packets with err held high; the first has busy
        // raised the cycle HEADER is entered.
        err = 1'b1;
        for (int i = 0; i < 17; i++) begin
            for (int w = 0; w < 7; w++) pl[w] = 3'((i + 3 * w + 1) & 7);
            ec = (i >= 14) ? 4'd15 : 4'(i + 1);
            run_pkt(2'(i % 3), 3'((i % 7) + 1), pl, 1'b0,
                    (i == 0) ? 2 : 0, ec);
        end
        err = 1'b0;

        // Reset while PAYLOAD is on the link.
        req_valid = 1'b1;
        req_addr  = 2'd0;
        req_len   = 3'd3;
        tick();
        req_valid = 1'b0;
        for (int w = 0; w < 3; w++) begin
            pay_valid = 1'b1;
            pay_data  = 3'(w + 1);
            tick();
        end
        pay_valid = 1'b0;
        tick();
        tick();
        chk("mid_pay", {1'b0, data_out}, 4'd1);
        chk("mid_pay_v", {3'd0, packet_valid}, 4'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("midrst", 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("postrst", 4'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
